multiplicador: RTL and testbench
================================

# multiplicador

Sequential shift-and-add unsigned multiplier. It is the inverse arithmetic unit of the restoring divider in the same datapath. It takes two W-bit operands on a START request and iterates one multiplier bit per two clock cycles. It then presents the 2W-bit product with a DONE flag. It sits beside the divider in the lab arithmetic unit and shares its START/DONE request style.

## Interface
- W, default 3, operand width in bits (legal range 2..16)
- clk  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- portA  input  W  multiplicand, sampled only on an accepted START
- portB  input  W  multiplier, sampled only on an accepted START
- START  input  1  level request, sampled in START_S only
- PP  output reg  2W  product, registered
- DONE  output reg  1  product valid, registered

## Operation
- Internal registers:
  - MD (W bits): multiplicand.
  - MR (W bits): multiplier, shifts right.
  - A (W+1 bits): accumulator; the extra bit holds the carry.
  - ct (clog2(W+1) bits): down counter.
- FSM states: START_S, ADD_S, SHIFT_DEC, END1.
- START_S:
  - DONE=0.
  - If START=1: load MD=portA, MR=portB, A=0, ct=W; go to ADD_S.
  - Else stay.
- ADD_S:
  - If MR[0]=1: A = A + {1'b0,MD}. Else A is unchanged.
  - Go to SHIFT_DEC.
- SHIFT_DEC:
  - {A,MR} = {A,MR} >> 1, with 0 shifted into the MSB of A.
  - ct = ct-1.
  - If the new ct is 0: go to END1, else go to ADD_S.
- END1:
  - On entry: PP = {A[W-1:0], MR}; DONE=1.
  - Stay while START=1. Go to START_S when START=0.
- PP is written only on entry to END1. It holds its value through START_S until the next product is written, including across a new computation.
- Width rules:
  - A never overflows W+1 bits.
  - The final A[W] is always 0.
  - Max product (2^W-1)^2 fits in 2W bits, so there is no truncation.
- Unsigned only. No early exit on zero operands, so latency is data-independent.

## Timing
- Reset (RST_N=0, asynchronous):
  - State=START_S.
  - PP=0, DONE=0, A=0, MD=0, MR=0, ct=0.
  - Takes effect immediately in any state, including mid-computation. The partial result is discarded and PP is cleared.
- Latency: START=1 sampled at edge E0. ADD_S/SHIFT_DEC alternate for W iterations. END1 is entered at edge E0+2W, so DONE and PP are valid after E0+2W (6 cycles for W=3).
- START during ADD_S, SHIFT_DEC or END1 is ignored. portA/portB changes after E0 have no effect.
- Handshake: DONE stays 1 while START stays 1.
  - START low at edge Ek in END1: DONE=0 after Ek (state START_S).
  - START high again at Ek+1: a new operation is accepted.
  - Minimum spacing between accepted requests: 2W+2 cycles.
- START held permanently high: exactly one operation; the block parks in END1.
- Reset released with START=1: the first accepted edge is the first rising clk after RST_N rises.

## Structure
- Shared package mult_div_pkg:
  - State encodings START_S=0, ADD_S=1, SHIFT_DEC=2, END1=3, sized 2 bits.
  - Default operand width constant W_DEF=3. The divider uses the same constant.
- One natural sub-module: contador_dec.
  - Parameterized down counter with load (INIT) and decrement (SH_DC) inputs, and a z output (count==0).
  - Asynchronous active-low reset.
  - Reusable by the divider.
- Everything else stays in multiplicador: one registered-state always block, one next-state/output block, one datapath block.

## Test plan
- W=3, portA=7, portB=7, one-cycle START pulse -> DONE rises exactly 6 cycles after the sampling edge, PP=49; PP stays 49 after START falls.
- W=3, 5×0 then 0×6, back-to-back with START toggled -> PP=0 both times, DONE low for at least 1 cycle between operations.
- W=3, 6×5 with START held high for 20 cycles -> PP=30, DONE stays 1 and no restart; START low -> DONE=0 next edge.
- W=3, start 3×3, pulse START again and change portA/portB during ADD_S/SHIFT_DEC -> ignored, PP=9 at cycle 6.
- W=3, start 7×6, drive RST_N low mid-SHIFT_DEC -> PP=0, DONE=0 immediately; after release, 2×3 gives PP=6 after 6 cycles.
- W=8, 255×255 and 128×2 -> PP=65025 and 256, DONE at 16 cycles.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the lab arithmetic unit (multiplier and divider).
// State encodings and the default operand width live here.
package mult_div_pkg;

    typedef enum logic [1:0] {
        START_S   = 2'd0,
        ADD_S     = 2'd1,
        SHIFT_DEC = 2'd2,
        END1      = 2'd3
    } state_t;

    localparam int W_DEF = 3;

endpackage

// File: rtl/contador_dec.sv
// Loadable down counter with a zero flag.
// Shared by the multiplier and the divider iteration control.
module contador_dec #(
    parameter int           N    = 2,
    parameter logic [N-1:0] LOAD = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic sh_dc,
    output logic z
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (init) begin
            cnt_d = LOAD;
        end else if (sh_dc && (cnt_q != '0)) begin
            cnt_d = cnt_q - N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign z = (cnt_q == '0);

endmodule

// File: rtl/multiplicador.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per two
// cycles, with a START/DONE level handshake.
module multiplicador
    import mult_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           RST_N,
    input  logic [W-1:0]   portA,
    input  logic [W-1:0]   portB,
    input  logic           START,
    output logic [2*W-1:0] PP,
    output logic           DONE
);

    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] CT_LOAD = CW'(W);

    state_t         state_q, state_d;
    logic [W-1:0]   md_q, md_d;
    logic [W-1:0]   mr_q, mr_d;
    logic [W:0]     a_q, a_d;
    logic [2*W-1:0] pp_q, pp_d;
    logic           done_q, done_d;

    logic           ld, add, shf;
    logic           ct_init, ct_dec, ct_z;
    logic [2*W:0]   sh;

    // ct steps down on leaving ADD_S, so SHIFT_DEC sees the updated count
    contador_dec #(
        .N    (CW),
        .LOAD (CT_LOAD)
    ) u_ct (
        .clk   (clk),
        .rst_n (RST_N),
        .init  (ct_init),
        .sh_dc (ct_dec),
        .z     (ct_z)
    );

    assign sh = {1'b0, a_q, mr_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pp_d    = pp_q;
        ld      = 1'b0;
        add     = 1'b0;
        shf     = 1'b0;
        ct_init = 1'b0;
        ct_dec  = 1'b0;
        unique case (state_q)
            START_S: begin
                done_d = 1'b0;
                if (START) begin
                    ld      = 1'b1;
                    ct_init = 1'b1;
                    state_d = ADD_S;
                end
            end
            ADD_S: begin
                add     = 1'b1;
                ct_dec  = 1'b1;
                state_d = SHIFT_DEC;
            end
            SHIFT_DEC: begin
                shf = 1'b1;
                if (ct_z) begin
                    pp_d    = sh[2*W-1:0];
                    done_d  = 1'b1;
                    state_d = END1;
                end else begin
                    state_d = ADD_S;
                end
            end
            END1: begin
                if (!START) begin
                    done_d  = 1'b0;
                    state_d = START_S;
                end
            end
            default: state_d = START_S;
        endcase
    end

    always_comb begin
        md_d = md_q;
        mr_d = mr_q;
        a_d  = a_q;
        if (ld) begin
            md_d = portA;
            mr_d = portB;
            a_d  = '0;
        end else if (add) begin
            if (mr_q[0]) begin
                a_d = a_q + {1'b0, md_q};
            end
        end else if (shf) begin
            a_d  = sh[2*W:W];
            mr_d = sh[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= START_S;
            md_q    <= '0;
            mr_q    <= '0;
            a_q     <= '0;
            pp_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
            mr_q    <= mr_d;
            a_q     <= a_d;
            pp_q    <= pp_d;
            done_q  <= done_d;
        end
    end

    assign PP   = pp_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador at W=3 and W=8.
module tb_multiplicador;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a3, b3;
    logic        start3;
    logic [5:0]  pp3;
    logic        done3;
    logic [7:0]  a8, b8;
    logic        start8;
    logic [15:0] pp8;
    logic        done8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multiplicador #(.W(3)) dut3 (
        .clk   (clk),
        .RST_N (rst_n),
        .portA (a3),
        .portB (b3),
        .START (start3),
        .PP    (pp3),
        .DONE  (done3)
    );

    multiplicador #(.W(8)) dut8 (
        .clk   (clk),
        .RST_N (rst_n),
        .portA (a8),
        .portB (b8),
        .START (start8),
        .PP    (pp8),
        .DONE  (done8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pp_of(input int w);
        return (w == 8) ? 32'(pp8) : 32'(pp3);
    endfunction

    function automatic logic [31:0] done_of(input int w);
        return (w == 8) ? 32'(done8) : 32'(done3);
    endfunction

    task automatic drive(input int w, input int a, input int b,
                         input logic s);
        if (w == 8) begin
            a8 = 8'(a); b8 = 8'(b); start8 = s;
        end else begin
            a3 = 3'(a); b3 = 3'(b); start3 = s;
        end
    endtask

    // One-cycle START pulse; checks exact DONE latency, product, release
    task automatic mul_op(input int w, input int a, input int b,
                          input int exp, input string tag);
        drive(w, a, b, 1'b1);
        @(negedge clk);
        drive(w, a, b, 1'b0);
        repeat (2 * w - 1) @(negedge clk);
        chk({tag, "_done_early"}, done_of(w), 0);
        @(negedge clk);
        chk({tag, "_done"}, done_of(w), 1);
        chk({tag, "_pp"}, pp_of(w), 32'(exp));
        @(negedge clk);
        chk({tag, "_done_drop"}, done_of(w), 0);
        chk({tag, "_pp_hold"}, pp_of(w), 32'(exp));
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0;
        drive(3, 0, 0, 1'b0);
        drive(8, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_pp3", 32'(pp3), 0);
        chk("rst_done3", 32'(done3), 0);
        chk("rst_pp8", 32'(pp8), 0);
        chk("rst_done8", 32'(done8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        mul_op(3, 7, 7, 49, "m7x7");
        mul_op(3, 5, 0, 0, "m5x0");
        mul_op(3, 0, 6, 0, "m0x6");

        // START held high: one operation, parked in END1
        drive(3, 6, 5, 1'b1);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("hold_done_early", 32'(done3), 0);
        @(negedge clk);
        chk("hold_done", 32'(done3), 1);
        chk("hold_pp", 32'(pp3), 30);
        ok = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (!done3 || pp3 != 6'd30) ok = 1'b0;
        end
        chk("hold_parked", 32'(ok), 1);
        start3 = 1'b0;
        @(negedge clk);
        chk("hold_release", 32'(done3), 0);
        chk("hold_pp_keep", 32'(pp3), 30);

        // START and operands disturbed mid-computation
        drive(3, 3, 3, 1'b1);
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        drive(3, 7, 7, 1'b1);
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("ign_done_early", 32'(done3), 0);
        @(negedge clk);
        chk("ign_done", 32'(done3), 1);
        chk("ign_pp", 32'(pp3), 9);
        @(negedge clk);
        chk("ign_done_drop", 32'(done3), 0);

        // Asynchronous reset during SHIFT_DEC
        drive(3, 7, 6, 1'b1);
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        chk("rst_mid_pp_old", 32'(pp3), 9);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pp", 32'(pp3), 0);
        chk("rst_mid_done", 32'(done3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mul_op(3, 2, 3, 6, "m2x3");

        mul_op(8, 255, 255, 65025, "m255x255");
        mul_op(8, 128, 2, 256, "m128x2");
        mul_op(8, 13, 11, 143, "m13x11");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
